// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared widths and scan FSM state encoding for mux_scan_ctrl
package mux_scan_ctrl_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SETTLE  = ST_SETTLE,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_next_chan_pe.sv
// rtl/mux_scan_ctrl_next_chan_pe.sv - priority encoder finding the next enabled channel
module next_chan_pe
  import mux_scan_ctrl_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             from_start,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Lowest set bit of mask, restricted to indices above cur unless the search starts a scan.
  // Walking downward lets the lowest qualifying index overwrite any higher one.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans enabled mux4x1 channels, settles, captures y into a result word
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_CH-1:0]  chan_mask,
  input  logic             y_in,
  output logic [SEL_W-1:0] s,
  output logic [N_CH-1:0]  sample,
  output logic             valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  cap_q, cap_d;
  logic [N_CH-1:0]  cap_new;
  logic [SEL_W-1:0] s_d;
  logic [N_CH-1:0]  sample_d;
  logic             valid_d;
  logic             busy_d;

  logic             pe_from_start;
  logic [N_CH-1:0]  pe_mask;
  logic [SEL_W-1:0] pe_nxt;
  logic             pe_found;

  // In IDLE the search runs on the live request mask; mid-scan it runs on the latched one.
  assign pe_from_start = (state_q == IDLE);
  assign pe_mask       = (state_q == IDLE) ? chan_mask : mask_q;

  next_chan_pe u_next_chan_pe (
    .mask       (pe_mask),
    .cur        (ch_q),
    .from_start (pe_from_start),
    .nxt        (pe_nxt),
    .found      (pe_found)
  );

  // Capture word with the current channel's bit replaced by the live mux output.
  always_comb begin
    cap_new        = cap_q;
    cap_new[ch_q]  = y_in;
  end

  // State and registered outputs; reset discards any partial scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      s       <= '0;
      sample  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      s       <= s_d;
      sample  <= sample_d;
      valid   <= valid_d;
      busy    <= busy_d;
    end
  end

  // Next-state and next-output logic; valid is raised only on the edge entering DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    cap_d    = cap_q;
    s_d      = s;
    sample_d = sample;
    valid_d  = 1'b0;
    busy_d   = busy;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mask_d = chan_mask;
          cap_d  = '0;
          if (pe_found) begin
            ch_d    = pe_nxt;
            s_d     = pe_nxt;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SETTLE;
          end else begin
            sample_d = '0;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      CAPTURE: begin
        cap_d = cap_new;
        if (pe_found) begin
          ch_d    = pe_nxt;
          s_d     = pe_nxt;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          sample_d = cap_new;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - randomized and directed checks of mux_scan_ctrl against a scan model
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [2];
  logic [3:0] mask_v  [2];
  logic [3:0] ivec    [2];
  logic       y_w     [2];
  logic [1:0] s_w     [2];
  logic [3:0] smp_w   [2];
  logic       vld_w   [2];
  logic       bsy_w   [2];
  int         last_s  [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // mux4x1 behaviour in front of each controller
  assign y_w[0] = ivec[0][s_w[0]];
  assign y_w[1] = ivec[1][s_w[1]];

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .chan_mask(mask_v[0]), .y_in(y_w[0]),
    .s(s_w[0]), .sample(smp_w[0]), .valid(vld_w[0]), .busy(bsy_w[0])
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .chan_mask(mask_v[1]), .y_in(y_w[1]),
    .s(s_w[1]), .sample(smp_w[1]), .valid(vld_w[1]), .busy(bsy_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check($sformatf("rst_s%0d", d),      32'(s_w[d]),   0);
    check($sformatf("rst_sample%0d", d), 32'(smp_w[d]), 0);
    check($sformatf("rst_valid%0d", d),  32'(vld_w[d]), 0);
    check($sformatf("rst_busy%0d", d),   32'(bsy_w[d]), 0);
  endtask

  // Model: each enabled channel, ascending, owns S+1 cycles of s; valid follows the last one.
  // iv_hi supplies the mux inputs while channel 3 is selected; restart pulses start mid-scan.
  task automatic scan(input int d, input logic [3:0] m, input logic [3:0] iv,
                      input logic [3:0] iv_hi, input bit restart);
    int         sc;
    int         exp_s[$];
    int         lat;
    int         pulses;
    logic [3:0] exp_smp;
    sc      = (d == 0) ? 2 : 1;
    exp_smp = 4'b0000;
    pulses  = 0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        repeat (sc + 1) exp_s.push_back(b);
        exp_smp[b] = (b == 3) ? iv_hi[b] : iv[b];
        last_s[d]  = b;
      end
    end
    lat = exp_s.size();
    start_v[d] = 1'b1;
    mask_v[d]  = m;
    ivec[d]    = (lat > 0 && exp_s[0] == 3) ? iv_hi : iv;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    mask_v[d]  = ~m;
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      ivec[d] = (c < lat && exp_s[c] == 3) ? iv_hi : iv;
      if (vld_w[d]) pulses++;
      check($sformatf("valid d%0d c%0d", d, c), 32'(vld_w[d]), 32'(c == lat));
      check($sformatf("busy d%0d c%0d", d, c),  32'(bsy_w[d]), 32'(c < lat));
      if (c < lat) check($sformatf("s d%0d c%0d", d, c), 32'(s_w[d]), exp_s[c]);
      else         check($sformatf("s_hold d%0d c%0d", d, c), 32'(s_w[d]), last_s[d]);
      if (c >= lat) check($sformatf("sample d%0d c%0d", d, c), 32'(smp_w[d]), 32'(exp_smp));
      if (restart && c == 3) begin
        start_v[d] = 1'b1;
        mask_v[d]  = 4'b0001;
      end else begin
        start_v[d] = 1'b0;
        mask_v[d]  = ~m;
      end
    end
    start_v[d] = 1'b0;
    check($sformatf("pulses d%0d", d), pulses, 1);
  endtask

  initial begin
    logic [3:0] rm;
    logic [3:0] ri;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      mask_v[d]  = 4'b0000;
      ivec[d]    = 4'b0000;
      last_s[d]  = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    scan(0, 4'b1111, 4'b1010, 4'b1010, 1'b0);
    scan(0, 4'b0101, 4'b1111, 4'b1111, 1'b0);
    scan(0, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    scan(0, 4'b1111, 4'b1100, 4'b1100, 1'b1);
    scan(1, 4'b1111, 4'b0011, 4'b1111, 1'b0);
    scan(1, 4'b1000, 4'b0000, 4'b1111, 1'b0);

    for (int n = 0; n < 12; n++) begin
      rm = 4'($urandom_range(0, 15));
      ri = 4'($urandom_range(0, 15));
      scan(n % 2, rm, ri, ri, 1'b0);
    end

    start_v[0] = 1'b1;
    mask_v[0]  = 4'b1111;
    ivec[0]    = 4'b1111;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    check("midscan_s_before_reset", 32'(s_w[0]), 2);
    check("midscan_busy_before_reset", 32'(bsy_w[0]), 1);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_s[0] = 0;
    last_s[1] = 0;
    repeat (2) @(negedge clk);
    check("post_reset_valid", 32'(vld_w[0]), 0);
    scan(0, 4'b1111, 4'b0110, 4'b0110, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
